// File: rtl/repairval_pattern_detector_pkg.sv
// Shared defaults and state encoding for the REPAIRVAL valid-lane detector.
// Imported by the interface, the run counter and the top.
package repairval_pattern_detector_pkg;

  localparam logic [7:0] DEF_VAL_PATTERN    = 8'hF0;
  localparam int         DEF_ITERATIONS     = 128;
  localparam int         DEF_PASS_THRESHOLD = 16;
  localparam int         CNT_W              = 8;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DETECT = 2'd1,
    ST_DONE   = 2'd2
  } state_t;

endpackage

// File: rtl/repairval_pattern_detector_if.sv
// Partner-FSM side bundle of the REPAIRVAL valid-lane detector.
// master drives words and control, slave returns result and status.
interface repairval_pattern_detector_if;
  import repairval_pattern_detector_pkg::*;

  logic             i_enable_detect;
  logic [7:0]       i_val_word;
  logic             i_val_word_vld;
  logic             i_detect_stop;
  logic             o_VAL_Result_logged;
  logic             o_result_valid;
  logic             o_detect_busy;
  logic [CNT_W-1:0] o_iter_count;

  modport master (
    output i_enable_detect,
    output i_val_word,
    output i_val_word_vld,
    output i_detect_stop,
    input  o_VAL_Result_logged,
    input  o_result_valid,
    input  o_detect_busy,
    input  o_iter_count
  );

  modport slave (
    input  i_enable_detect,
    input  i_val_word,
    input  i_val_word_vld,
    input  i_detect_stop,
    output o_VAL_Result_logged,
    output o_result_valid,
    output o_detect_busy,
    output o_iter_count
  );

endinterface

// File: rtl/repairval_run_counter.sv
// Pattern compare, saturating run of consecutive matches, sticky pass.
// pass_nxt is the flag value after this edge, so the current word counts.
module repairval_run_counter
  import repairval_pattern_detector_pkg::*;
#(
  parameter logic [7:0] PATTERN   = DEF_VAL_PATTERN,
  parameter int         THRESHOLD = DEF_PASS_THRESHOLD
) (
  input  logic       CLK,
  input  logic       rst,
  input  logic       clr,
  input  logic       en,
  input  logic [7:0] word,
  output logic       pass_nxt
);

  localparam logic [CNT_W-1:0] TH = CNT_W'(THRESHOLD);

  logic [CNT_W-1:0] run;
  logic [CNT_W-1:0] run_nxt;
  logic             pass;

  always_comb begin
    run_nxt = run;
    if (clr) begin
      run_nxt = '0;
    end else if (en) begin
      if (word != PATTERN) begin
        run_nxt = '0;
      end else if (run < TH) begin
        run_nxt = run + 1'b1;
      end
    end
    pass_nxt = !clr && (pass || (run_nxt == TH));
  end

  always_ff @(posedge CLK or posedge rst) begin
    if (rst) begin
      run  <= '0;
      pass <= 1'b0;
    end else begin
      run  <= run_nxt;
      pass <= pass_nxt;
    end
  end

endmodule

// File: rtl/repairval_pattern_detector.sv
// REPAIRVAL valid-lane pattern detector: counts iterations in a window,
// logs pass/fail once per completed window with a one-cycle valid pulse.
module repairval_pattern_detector
  import repairval_pattern_detector_pkg::*;
#(
  parameter logic [7:0] VAL_PATTERN    = DEF_VAL_PATTERN,
  parameter int         ITERATIONS     = DEF_ITERATIONS,
  parameter int         PASS_THRESHOLD = DEF_PASS_THRESHOLD
) (
  input logic                   CLK,
  input logic                   rst,
  repairval_pattern_detector_if.slave bus
);

  localparam logic [CNT_W-1:0] ITER = CNT_W'(ITERATIONS);

  state_t           state;
  state_t           state_nxt;
  logic             clr;
  logic             accept;
  logic             last_word;
  logic             finalize;
  logic             pass_nxt;
  logic [CNT_W-1:0] iter_cnt;
  logic             logged;
  logic             rvalid;
  logic             busy;

  // enable low wins over a coincident word: the window is abandoned
  assign accept = (state == ST_DETECT) && bus.i_enable_detect
               && bus.i_val_word_vld;
  assign last_word = accept && (iter_cnt == ITER - 1'b1);

  always_comb begin
    state_nxt = state;
    clr       = 1'b0;
    finalize  = 1'b0;
    unique case (state)
      ST_IDLE: begin
        if (bus.i_enable_detect) begin
          state_nxt = ST_DETECT;
          clr       = 1'b1;
        end
      end
      ST_DETECT: begin
        if (!bus.i_enable_detect) begin
          state_nxt = ST_IDLE;
        end else if (last_word || bus.i_detect_stop) begin
          state_nxt = ST_DONE;
          finalize  = 1'b1;
        end
      end
      ST_DONE: begin
        if (!bus.i_enable_detect) begin
          state_nxt = ST_IDLE;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLK or posedge rst) begin
    if (rst) begin
      state    <= ST_IDLE;
      iter_cnt <= '0;
      logged   <= 1'b0;
      rvalid   <= 1'b0;
      busy     <= 1'b0;
    end else begin
      state  <= state_nxt;
      rvalid <= finalize;
      busy   <= (state_nxt == ST_DETECT);
      if (clr) begin
        iter_cnt <= '0;
      end else if (accept && (iter_cnt != ITER)) begin
        iter_cnt <= iter_cnt + 1'b1;
      end
      if (clr) begin
        logged <= 1'b0;
      end else if (finalize) begin
        logged <= pass_nxt;
      end
    end
  end

  repairval_run_counter #(
    .PATTERN  (VAL_PATTERN),
    .THRESHOLD(PASS_THRESHOLD)
  ) u_run (
    .CLK     (CLK),
    .rst     (rst),
    .clr     (clr),
    .en      (accept),
    .word    (bus.i_val_word),
    .pass_nxt(pass_nxt)
  );

  assign bus.o_VAL_Result_logged = logged;
  assign bus.o_result_valid      = rvalid;
  assign bus.o_detect_busy       = busy;
  assign bus.o_iter_count        = iter_cnt;

endmodule

// File: tb/tb_repairval_pattern_detector.sv
// Scoreboard bench for the REPAIRVAL valid-lane pattern detector.
// Expected results are queued as words are driven, popped on each pulse.
module tb_repairval_pattern_detector;
  import repairval_pattern_detector_pkg::*;

  localparam int ITER = 128;
  localparam int TH   = 16;

  typedef struct packed {
    logic       logged;
    logic [7:0] cnt;
  } exp_t;

  logic CLK = 1'b0;
  logic rst = 1'b1;
  always #5 CLK = ~CLK;

  repairval_pattern_detector_if dif();

  repairval_pattern_detector #(
    .VAL_PATTERN   (8'hF0),
    .ITERATIONS    (ITER),
    .PASS_THRESHOLD(TH)
  ) dut (
    .CLK(CLK),
    .rst(rst),
    .bus(dif)
  );

  exp_t sb[$];
  exp_t mon_e;
  int   n_checks = 0;
  int   n_errors = 0;
  int   n_pulses = 0;
  int   m_cnt, m_run, p0;
  bit   m_pass, m_active;

  task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic start_window();
    dif.i_enable_detect = 1'b1;
    m_cnt = 0;
    m_run = 0;
    m_pass = 1'b0;
    m_active = 1'b1;
    tick();
  endtask

  task automatic drop_window();
    dif.i_enable_detect = 1'b0;
    m_active = 1'b0;
    tick();
  endtask

  task automatic send(logic [7:0] w, bit stop = 1'b0);
    exp_t e;
    dif.i_val_word     = w;
    dif.i_val_word_vld = 1'b1;
    dif.i_detect_stop  = stop;
    if (m_active) begin
      m_cnt++;
      if (w == 8'hF0) m_run = (m_run >= TH) ? TH : m_run + 1;
      else m_run = 0;
      if (m_run == TH) m_pass = 1'b1;
      if (m_cnt == ITER || stop) begin
        e.logged = m_pass;
        e.cnt    = 8'(m_cnt);
        sb.push_back(e);
        m_active = 1'b0;
      end
    end
    tick();
    dif.i_val_word_vld = 1'b0;
    dif.i_detect_stop  = 1'b0;
  endtask

  always @(negedge CLK) begin
    if (!rst && dif.o_result_valid) begin
      n_pulses++;
      if (sb.size() == 0) begin
        chk("unexpected_pulse", 1, 0);
      end else begin
        mon_e = sb.pop_front();
        chk("sb_logged", 32'(dif.o_VAL_Result_logged), 32'(mon_e.logged));
        chk("sb_iter_count", 32'(dif.o_iter_count), 32'(mon_e.cnt));
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    dif.i_enable_detect = 1'b0;
    dif.i_val_word      = 8'h00;
    dif.i_val_word_vld  = 1'b0;
    dif.i_detect_stop   = 1'b0;
    m_active = 1'b0;
    repeat (2) tick();
    chk("rst_logged", 32'(dif.o_VAL_Result_logged), 0);
    chk("rst_valid", 32'(dif.o_result_valid), 0);
    chk("rst_busy", 32'(dif.o_detect_busy), 0);
    chk("rst_iter", 32'(dif.o_iter_count), 0);
    rst = 1'b0;
    tick();

    // all-match window
    p0 = n_pulses;
    start_window();
    chk("s1_busy", 32'(dif.o_detect_busy), 1);
    chk("s1_iter0", 32'(dif.o_iter_count), 0);
    for (int i = 0; i < ITER; i++) send(8'hF0);
    chk("s1_valid", 32'(dif.o_result_valid), 1);
    chk("s1_logged", 32'(dif.o_VAL_Result_logged), 1);
    chk("s1_iter", 32'(dif.o_iter_count), 128);
    chk("s1_busy_done", 32'(dif.o_detect_busy), 0);
    tick();
    chk("s1_valid_drop", 32'(dif.o_result_valid), 0);
    drop_window();
    chk("s1_idle_busy", 32'(dif.o_detect_busy), 0);
    chk("s1_retained", 32'(dif.o_VAL_Result_logged), 1);
    send(8'hF0, 1'b1);
    repeat (2) tick();
    chk("s1_idle_iter", 32'(dif.o_iter_count), 128);
    chk("s1_pulses", 32'(n_pulses - p0), 1);

    // every 10th word corrupted: max run 9
    p0 = n_pulses;
    start_window();
    for (int i = 0; i < ITER; i++) send((i % 10 == 9) ? 8'h0F : 8'hF0);
    chk("s2_valid", 32'(dif.o_result_valid), 1);
    chk("s2_logged", 32'(dif.o_VAL_Result_logged), 0);
    tick();
    drop_window();
    chk("s2_pulses", 32'(n_pulses - p0), 1);

    // early stop on the word that completes the run
    p0 = n_pulses;
    start_window();
    for (int i = 0; i < 15; i++) send(8'hF0);
    send(8'h0F);
    for (int i = 0; i < 15; i++) send(8'hF0);
    send(8'hF0, 1'b1);
    chk("s3_valid", 32'(dif.o_result_valid), 1);
    chk("s3_logged", 32'(dif.o_VAL_Result_logged), 1);
    chk("s3_iter", 32'(dif.o_iter_count), 32);
    send(8'hF0);
    chk("s3_done_iter", 32'(dif.o_iter_count), 32);
    send(8'hF0, 1'b1);
    tick();
    chk("s3_pulses", 32'(n_pulses - p0), 1);
    drop_window();

    // abandoned window, then saturation
    p0 = n_pulses;
    start_window();
    for (int i = 0; i < 50; i++) send(8'hF0);
    drop_window();
    chk("s4_busy", 32'(dif.o_detect_busy), 0);
    chk("s4_logged", 32'(dif.o_VAL_Result_logged), 0);
    tick();
    chk("s4_nopulse", 32'(n_pulses - p0), 0);
    start_window();
    for (int i = 0; i < 130; i++) send(8'hF0);
    chk("s4_iter_sat", 32'(dif.o_iter_count), 128);
    chk("s4_logged2", 32'(dif.o_VAL_Result_logged), 1);
    chk("s4_pulses", 32'(n_pulses - p0), 1);
    drop_window();

    // asynchronous reset mid-window
    p0 = n_pulses;
    start_window();
    for (int i = 0; i < 60; i++) send(8'hF0);
    @(posedge CLK);
    #3;
    rst = 1'b1;
    m_active = 1'b0;
    #1;
    chk("s5_iter", 32'(dif.o_iter_count), 0);
    chk("s5_busy", 32'(dif.o_detect_busy), 0);
    chk("s5_logged", 32'(dif.o_VAL_Result_logged), 0);
    chk("s5_valid", 32'(dif.o_result_valid), 0);
    dif.i_enable_detect = 1'b0;
    repeat (3) tick();
    rst = 1'b0;
    repeat (5) tick();
    chk("s5_nopulse", 32'(n_pulses - p0), 0);
    chk("s5_idle", 32'(dif.o_detect_busy), 0);

    chk("sb_empty", 32'(sb.size()), 0);
    $display("Simulation finished: %0d checks, %0d errors",
             n_checks, n_errors);
    $finish;
  end

endmodule
